phase_generator: RTL and testbench

- Upstream stage of the sine-lookup memory: a numerically controlled oscillator (NCO) that produces the 9-bit phase address (0–511, one full wave) driving the lookup's read_address.
- Phase advances once per prescaled sample tick by a frequency tuning word (FTW).
- Supports fixed-frequency mode and linear chirp (sweep) modes, with FTW configuration via a valid/ready handshake.
- Emits sample_valid aligned to the lookup's 2-edge read latency, so the consumer can register read_data on that pulse.

---
 rtl/phase_generator.sv | 93 +++++++++
 tb/tb_phase_generator.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/phase_generator.sv
// phase_generator: prescaled NCO producing the 9-bit sine lookup address, with fixed and chirp modes.
module phase_generator #(
    parameter int ACC_WIDTH  = 24,
    parameter int SAMPLE_DIV = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 phase_reset,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [ACC_WIDTH-1:0] cfg_ftw,
    input  logic [ACC_WIDTH-1:0] cfg_step,
    input  logic [ACC_WIDTH-1:0] cfg_stop,
    input  logic [1:0]           cfg_mode,
    output logic [8:0]           read_address,
    output logic                 sample_valid,
    output logic                 sweep_done,
    output logic                 busy
);
    localparam int PW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 2;
    localparam logic [PW-1:0] LAST = PW'(SAMPLE_DIV - 1);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, SWEEP = 2'd2, DONE = 2'd3} state_t;
    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d, ftw_q, ftw_d, start_q, start_d, step_q, step_d, stop_q, stop_d;
    logic [1:0]           mode_q, mode_d;
    logic [PW-1:0]        cnt_q, cnt_d;
    logic [2:0]           pipe_q, pipe_d;
    logic                 done_q, done_d;
    logic                 run, tick, accept, hit, once;
    logic [ACC_WIDTH:0]   nxt;
    always_comb begin
        run       = enable && state_q != IDLE;
        tick      = run && cnt_q == LAST && !phase_reset;
        cfg_ready = (state_q == SWEEP) ? !enable : 1'b1;
        accept    = cfg_valid && cfg_ready;
        once      = mode_q == 2'b01;
        nxt       = {1'b0, ftw_q} + {1'b0, step_q};
        hit       = step_q != '0 && (nxt[ACC_WIDTH] || nxt[ACC_WIDTH-1:0] >= stop_q);
        state_d   = state_q;
        ftw_d     = ftw_q;
        start_d   = start_q;
        step_d    = step_q;
        stop_d    = stop_q;
        mode_d    = mode_q;
        cnt_d     = phase_reset ? '0 : run ? (cnt_q == LAST ? '0 : cnt_q + 1'b1) : cnt_q;
        acc_d     = phase_reset ? '0 : tick ? acc_q + ftw_q : acc_q;
        pipe_d    = phase_reset ? '0 : enable ? {pipe_q[1:0], tick} : pipe_q;
        done_d    = tick && state_q == SWEEP && hit && once;
        if (tick && state_q == SWEEP) begin
            ftw_d   = hit ? (once ? stop_q : start_q) : nxt[ACC_WIDTH-1:0];
            state_d = (hit && once) ? DONE : SWEEP;
        end
        // In SWEEP an accept needs enable low, so it never collides with a sweep tick.
        if (accept) begin
            ftw_d   = cfg_ftw;
            start_d = cfg_ftw;
            step_d  = cfg_step;
            stop_d  = cfg_stop;
            mode_d  = cfg_mode;
            state_d = (cfg_mode == 2'b01 || cfg_mode == 2'b10) ? SWEEP : RUN;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ftw_q   <= '0;
            start_q <= '0;
            step_q  <= '0;
            stop_q  <= '0;
            mode_q  <= '0;
            cnt_q   <= '0;
            pipe_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ftw_q   <= ftw_d;
            start_q <= start_d;
            step_q  <= step_d;
            stop_q  <= stop_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            pipe_q  <= pipe_d;
            done_q  <= done_d;
        end
    end
    assign read_address = acc_q[ACC_WIDTH-1 -: 9];
    assign sample_valid = pipe_q[2];
    assign sweep_done   = done_q;
    assign busy         = state_q != IDLE;
endmodule

// File: tb/tb_phase_generator.sv
// tb_phase_generator: directed scenario tasks with hand-computed addresses for phase_generator.
module tb_phase_generator;
    logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, phase_reset = 1'b0, cfg_valid = 1'b0;
    logic [23:0] cfg_ftw = '0, cfg_step = '0, cfg_stop = '0;
    logic [1:0]  cfg_mode = '0;
    logic        cfg_ready, sample_valid, sweep_done, busy;
    logic [8:0]  read_address;
    int          errors = 0, checks = 0;

    phase_generator #(.ACC_WIDTH(24), .SAMPLE_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .phase_reset(phase_reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ftw(cfg_ftw), .cfg_step(cfg_step),
        .cfg_stop(cfg_stop), .cfg_mode(cfg_mode), .read_address(read_address),
        .sample_valid(sample_valid), .sweep_done(sweep_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b0; phase_reset = 1'b0; cfg_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1; enable = 1'b1;
        step();
    endtask

    task automatic send_cfg(input logic [23:0] f, input logic [23:0] s, input logic [23:0] p, input logic [1:0] m);
        cfg_valid = 1'b1; cfg_ftw = f; cfg_step = s; cfg_stop = p; cfg_mode = m;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (read_address !== 9'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", read_address); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", sample_valid); end
        checks++; if (sweep_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", sweep_done); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", cfg_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        do_reset();
        repeat (8) step();
        checks++; if (read_address !== 9'd0 || busy !== 1'b0) begin errors++; $display("FAIL idle_no_tick addr=%0d busy=%b exp=0/0", read_address, busy); end
    endtask

    task automatic test_fixed();
        logic [8:0] e;
        do_reset();
        send_cfg(24'h010000, 24'h0, 24'h0, 2'b00);
        checks++; if (busy !== 1'b1 || cfg_ready !== 1'b1) begin errors++; $display("FAIL fixed_state busy=%b ready=%b exp=1/1", busy, cfg_ready); end
        repeat (4) step();
        for (int i = 1; i <= 256; i++) begin
            e = 9'(2 * i);
            checks++; if (read_address !== e) begin errors++; $display("FAIL fixed_addr tick=%0d got=%0d exp=%0d", i, read_address, e); end
            step();
            checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL fixed_valid_early tick=%0d got=%b exp=0", i, sample_valid); end
            step();
            checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL fixed_valid tick=%0d got=%b exp=1", i, sample_valid); end
            step();
            step();
        end
    endtask

    task automatic test_sweep(input logic [1:0] m);
        int exp_once[6] = '{2, 6, 12, 20, 28, 36};
        int exp_loop[6] = '{2, 6, 12, 14, 18, 24};
        int e, done_cnt;
        done_cnt = 0;
        do_reset();
        send_cfg(24'h010000, 24'h010000, 24'h040000, m);
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL sweep_ready mode=%0d got=%b exp=0", m, cfg_ready); end
        repeat (4) step();
        for (int k = 0; k < 6; k++) begin
            e = (m == 2'b01) ? exp_once[k] : exp_loop[k];
            checks++; if (read_address !== 9'(e)) begin errors++; $display("FAIL sweep_addr mode=%0d tick=%0d got=%0d exp=%0d", m, k + 1, read_address, e); end
            if (m == 2'b01 && k == 2) begin
                checks++; if (sweep_done !== 1'b1) begin errors++; $display("FAIL sweep_done_timing got=%b exp=1", sweep_done); end
            end
            for (int j = 0; j < 4; j++) begin
                done_cnt += int'(sweep_done);
                step();
            end
        end
        e = (m == 2'b01) ? 1 : 0;
        checks++; if (done_cnt !== e) begin errors++; $display("FAIL sweep_done_count mode=%0d got=%0d exp=%0d", m, done_cnt, e); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sweep_busy mode=%0d got=%b exp=1", m, busy); end
        checks++; if (cfg_ready !== (m == 2'b01)) begin errors++; $display("FAIL sweep_end_ready mode=%0d got=%b exp=%b", m, cfg_ready, m == 2'b01); end
    endtask

    task automatic test_phase_reset();
        do_reset();
        send_cfg(24'h010000, 24'h0, 24'h0, 2'b00);
        repeat (4 * 49) step();
        checks++; if (read_address !== 9'd98) begin errors++; $display("FAIL preset_pre got=%0d exp=98", read_address); end
        repeat (3) step();
        phase_reset = 1'b1;
        step();
        phase_reset = 1'b0;
        checks++; if (read_address !== 9'd0) begin errors++; $display("FAIL preset_addr got=%0d exp=0", read_address); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL preset_busy got=%b exp=1", busy); end
        step();
        step();
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL preset_no_valid got=%b exp=0", sample_valid); end
        step();
        step();
        checks++; if (read_address !== 9'd2) begin errors++; $display("FAIL preset_next got=%0d exp=2", read_address); end
        step();
        step();
        checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL preset_valid_back got=%b exp=1", sample_valid); end
    endtask

    task automatic test_freeze();
        do_reset();
        send_cfg(24'h010000, 24'h010000, 24'h040000, 2'b01);
        repeat (5) step();
        checks++; if (read_address !== 9'd2 || sample_valid !== 1'b0) begin errors++; $display("FAIL freeze_pre addr=%0d valid=%b exp=2/0", read_address, sample_valid); end
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++; if (read_address !== 9'd2 || sample_valid !== 1'b0) begin errors++; $display("FAIL freeze_hold cyc=%0d addr=%0d valid=%b exp=2/0", i, read_address, sample_valid); end
        end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL freeze_ready got=%b exp=1", cfg_ready); end
        enable = 1'b1;
        step();
        checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL freeze_valid_resume got=%b exp=1", sample_valid); end
        step();
        step();
        checks++; if (read_address !== 9'd6) begin errors++; $display("FAIL freeze_tick2 got=%0d exp=6", read_address); end
        repeat (4) step();
        checks++; if (read_address !== 9'd12) begin errors++; $display("FAIL freeze_tick3 got=%0d exp=12", read_address); end
        repeat (4) step();
        checks++; if (read_address !== 9'd20) begin errors++; $display("FAIL freeze_tick4 got=%0d exp=20", read_address); end
    endtask

    task automatic test_cfg_on_tick();
        do_reset();
        send_cfg(24'h010000, 24'h0, 24'h0, 2'b00);
        repeat (7) step();
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL retune_ready got=%b exp=1", cfg_ready); end
        cfg_valid = 1'b1; cfg_ftw = 24'h020000; cfg_step = '0; cfg_stop = '0; cfg_mode = 2'b00;
        step();
        cfg_valid = 1'b0;
        checks++; if (read_address !== 9'd4) begin errors++; $display("FAIL retune_tick got=%0d exp=4", read_address); end
        repeat (4) step();
        checks++; if (read_address !== 9'd8) begin errors++; $display("FAIL retune_next got=%0d exp=8", read_address); end
        repeat (4) step();
        checks++; if (read_address !== 9'd12) begin errors++; $display("FAIL retune_after got=%0d exp=12", read_address); end
    endtask

    task automatic test_mode3_and_async();
        do_reset();
        send_cfg(24'h010000, 24'h010000, 24'h040000, 2'b11);
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL mode3_ready got=%b exp=1", cfg_ready); end
        repeat (12) step();
        checks++; if (read_address !== 9'd6) begin errors++; $display("FAIL mode3_addr got=%0d exp=6", read_address); end
        rst_n = 1'b0;
        #1;
        checks++; if (read_address !== 9'd0 || busy !== 1'b0) begin errors++; $display("FAIL async_reset addr=%0d busy=%b exp=0/0", read_address, busy); end
        step();
        rst_n = 1'b1;
        repeat (8) step();
        checks++; if (read_address !== 9'd0 || busy !== 1'b0) begin errors++; $display("FAIL async_cfg_lost addr=%0d busy=%b exp=0/0", read_address, busy); end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_sweep(2'b01);
        test_sweep(2'b10);
        test_phase_reset();
        test_freeze();
        test_cfg_on_tick();
        test_mode3_and_async();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
